// File: rtl/gate_mux_checker_pkg.sv
// Shared types and sizing for the NAND/NOR truth-table checker.
package gate_mux_checker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StCheck,
    StDone
  } state_e;

  localparam int unsigned NumVectors = 4;
  localparam int unsigned ErrCntW    = 3;
  localparam int unsigned IdxW       = 2;
  localparam int unsigned SettleW    = 4;

  localparam logic [IdxW-1:0]    LastIdx = IdxW'(NumVectors - 1);
  localparam logic [ErrCntW-1:0] ErrMax  = ErrCntW'(NumVectors);

endpackage

// File: rtl/gate_expect.sv
// Reference NAND/NOR results for the operand pair currently driven.
module gate_expect (
  input  logic a,
  input  logic b,
  output logic exp_nand,
  output logic exp_nor
);

  assign exp_nand = ~(a & b);
  assign exp_nor  = ~(a | b);

endmodule

// File: rtl/gate_mux_checker.sv
// Walks the four operand pairs through an external NAND/NOR device and
// records which vectors returned a wrong result.
module gate_mux_checker
  import gate_mux_checker_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  nand_in,
  input  logic                  nor_in,
  output logic                  a,
  output logic                  b,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ErrCntW-1:0]    err_count,
  output logic [NumVectors-1:0] fail_vec
);

  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);

  state_e                  r_state, w_state_next;
  logic [IdxW-1:0]         r_idx, w_idx_next;
  logic [SettleW-1:0]      r_settle, w_settle_next;
  logic [ErrCntW-1:0]      r_err_count, w_err_next;
  logic [NumVectors-1:0]   r_fail_vec, w_fail_next;
  logic                    w_exp_nand, w_exp_nor, w_mismatch;

  gate_expect u_gate_expect (
    .a        (a),
    .b        (b),
    .exp_nand (w_exp_nand),
    .exp_nor  (w_exp_nor)
  );

  assign busy      = (r_state == StApply) || (r_state == StCheck);
  assign a         = busy & r_idx[1];
  assign b         = busy & r_idx[0];
  assign done      = (r_state == StDone);
  assign pass      = done && (r_err_count == '0);
  assign err_count = r_err_count;
  assign fail_vec  = r_fail_vec;

  assign w_mismatch = (nand_in != w_exp_nand) || (nor_in != w_exp_nor);

  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_settle_next = r_settle;
    w_err_next    = r_err_count;
    w_fail_next   = r_fail_vec;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_state_next  = StApply;
          w_idx_next    = '0;
          w_settle_next = '0;
          w_err_next    = '0;
          w_fail_next   = '0;
        end
      end
      StApply: begin
        if (r_settle == SettleLast) begin
          w_state_next  = StCheck;
          w_settle_next = '0;
        end else begin
          w_settle_next = r_settle + 1'b1;
        end
      end
      StCheck: begin
        if (w_mismatch) begin
          w_fail_next[r_idx] = 1'b1;
          // Saturate; only reachable as a guard since there are four vectors.
          if (r_err_count != ErrMax) w_err_next = r_err_count + 1'b1;
        end
        if (r_idx == LastIdx) begin
          w_state_next = StDone;
        end else begin
          w_state_next = StApply;
          w_idx_next   = r_idx + 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_settle    <= '0;
      r_err_count <= '0;
      r_fail_vec  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_settle    <= w_settle_next;
      r_err_count <= w_err_next;
      r_fail_vec  <= w_fail_next;
    end
  end

endmodule
